// File: rtl/miter_divergence_monitor.sv
// Compares NUM_CH output streams of two design copies and records the first divergence.
// Latency: an event is visible one cycle after the offending beats are sampled.
// Backpressure: none; purely observational, every beat is consumed the cycle it is seen.
module miter_divergence_monitor #(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 64,
  parameter int SKEW_DEPTH = 4,
  parameter int CYC_W      = 32,
  parameter int MODE       = 0,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        a_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] a_data_i,
  input  logic [NUM_CH-1:0]        b_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] b_data_i,
  output logic                     diverged_o,
  output logic [CH_W-1:0]          div_ch_o,
  output logic [1:0]               div_cause_o,
  output logic [CYC_W-1:0]         div_cycle_o,
  output logic [CYC_W-1:0]         cycle_o,
  output logic [NUM_CH-1:0]        pending_o
);

  localparam int PTR_W = $clog2(SKEW_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_DATA = 2'b01;
  localparam logic [1:0] CAUSE_VLD  = 2'b10;
  localparam logic [1:0] CAUSE_OVF  = 2'b11;

  // Per-channel skew buffers: lead_q marks which copy the buffered beats came from (0 = A, 1 = B).
  logic [DATA_W-1:0] mem_q    [NUM_CH][SKEW_DEPTH];
  logic [DATA_W-1:0] mem_d    [NUM_CH][SKEW_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [NUM_CH];
  logic [PTR_W-1:0]  wr_ptr_d [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr_q [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  cnt_d    [NUM_CH];
  logic [NUM_CH-1:0] lead_q, lead_d;

  logic [1:0]        cause [NUM_CH];

  logic              diverged_q, diverged_d;
  logic [CH_W-1:0]   div_ch_q, div_ch_d;
  logic [1:0]        div_cause_q, div_cause_d;
  logic [CYC_W-1:0]  div_cycle_q, div_cycle_d;
  logic [CYC_W-1:0]  cycle_q, cycle_d;

  // Per-channel event classification and skew-buffer next state.
  always_comb begin
    logic              a_v, b_v, empty, full, push, pop;
    logic [DATA_W-1:0] a_dat, b_dat, head, push_dat;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    lead_d   = lead_q;
    for (int k = 0; k < NUM_CH; k++) begin
      a_v      = a_valid_i[k];
      b_v      = b_valid_i[k];
      a_dat    = a_data_i[k*DATA_W +: DATA_W];
      b_dat    = b_data_i[k*DATA_W +: DATA_W];
      empty    = (cnt_q[k] == '0);
      full     = (cnt_q[k] == CNT_W'(SKEW_DEPTH));
      head     = mem_q[k][rd_ptr_q[k]];
      push     = 1'b0;
      pop      = 1'b0;
      push_dat = a_dat;
      cause[k] = CAUSE_NONE;
      if (MODE == 0) begin
        if (a_v != b_v) begin
          cause[k] = CAUSE_VLD;
        end else if (a_v && (a_dat != b_dat)) begin
          cause[k] = CAUSE_DATA;
        end
      end else begin
        case ({a_v, b_v})
          2'b10: begin
            if (empty || !lead_q[k]) begin
              // A is ahead (or level): buffer its beat unless there is no room.
              if (full) begin
                cause[k] = CAUSE_OVF;
              end else begin
                push      = 1'b1;
                push_dat  = a_dat;
                lead_d[k] = 1'b0;
              end
            end else begin
              // A catches up with a buffered B beat.
              pop = 1'b1;
              if (head != a_dat) cause[k] = CAUSE_DATA;
            end
          end
          2'b01: begin
            if (empty || lead_q[k]) begin
              if (full) begin
                cause[k] = CAUSE_OVF;
              end else begin
                push      = 1'b1;
                push_dat  = b_dat;
                lead_d[k] = 1'b1;
              end
            end else begin
              pop = 1'b1;
              if (head != b_dat) cause[k] = CAUSE_DATA;
            end
          end
          2'b11: begin
            if (empty) begin
              if (a_dat != b_dat) cause[k] = CAUSE_DATA;
            end else begin
              // Lagging side retires the head while the leading side refills the tail.
              pop  = 1'b1;
              push = 1'b1;
              if (!lead_q[k]) begin
                push_dat = a_dat;
                if (head != b_dat) cause[k] = CAUSE_DATA;
              end else begin
                push_dat = b_dat;
                if (head != a_dat) cause[k] = CAUSE_DATA;
              end
            end
          end
          default: ;
        endcase
        if (push) begin
          mem_d[k][wr_ptr_q[k]] = push_dat;
          wr_ptr_d[k]           = wr_ptr_q[k] + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr_d[k] = rd_ptr_q[k] + PTR_W'(1);
        end
        if (push && !pop) begin
          cnt_d[k] = cnt_q[k] + CNT_W'(1);
        end else if (pop && !push) begin
          cnt_d[k] = cnt_q[k] - CNT_W'(1);
        end
      end
    end
  end

  // Saturating cycle counter and first-divergence capture (lowest channel wins, then frozen).
  always_comb begin
    cycle_d     = (cycle_q == '1) ? cycle_q : cycle_q + CYC_W'(1);
    diverged_d  = diverged_q;
    div_ch_d    = div_ch_q;
    div_cause_d = div_cause_q;
    div_cycle_d = div_cycle_q;
    if (!diverged_q) begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        if (cause[k] != CAUSE_NONE) begin
          diverged_d  = 1'b1;
          div_ch_d    = CH_W'(k);
          div_cause_d = cause[k];
          div_cycle_d = cycle_q;
        end
      end
    end
  end

  // Residual skew indication per channel.
  always_comb begin
    pending_o = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      pending_o[k] = (MODE != 0) && (cnt_q[k] != '0);
    end
  end

  // State registers; reset takes priority over any beat in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '{default: '0};
      rd_ptr_q    <= '{default: '0};
      cnt_q       <= '{default: '0};
      lead_q      <= '0;
      diverged_q  <= 1'b0;
      div_ch_q    <= '0;
      div_cause_q <= CAUSE_NONE;
      div_cycle_q <= '0;
      cycle_q     <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      lead_q      <= lead_d;
      diverged_q  <= diverged_d;
      div_ch_q    <= div_ch_d;
      div_cause_q <= div_cause_d;
      div_cycle_q <= div_cycle_d;
      cycle_q     <= cycle_d;
    end
  end

  assign diverged_o  = diverged_q;
  assign div_ch_o    = div_ch_q;
  assign div_cause_o = div_cause_q;
  assign div_cycle_o = div_cycle_q;
  assign cycle_o     = cycle_q;

endmodule

// File: tb/tb_miter_divergence_monitor.sv
// Bench: lockstep instance, skew-tolerant instance and a narrow-counter instance
// checked every cycle against a queue-based reference model, plus directed scenarios.
module tb_miter_divergence_monitor;

  localparam int NCH = 2;
  localparam int DW  = 16;
  localparam int SD  = 4;

  logic clk;
  logic rst;

  logic [NCH-1:0]    a_v [2];
  logic [NCH*DW-1:0] a_d [2];
  logic [NCH-1:0]    b_v [2];
  logic [NCH*DW-1:0] b_d [2];
  logic [NCH-1:0]    z_v;
  logic [NCH*DW-1:0] z_d;

  logic              dv     [3];
  logic [0:0]        dch    [3];
  logic [1:0]        dcause [3];
  logic [NCH-1:0]    pend   [3];
  logic [31:0]       dcyc   [2];
  logic [31:0]       cyc    [2];
  logic [2:0]        dcyc_s, cyc_s;

  miter_divergence_monitor #(.NUM_CH(NCH), .DATA_W(DW), .SKEW_DEPTH(SD), .CYC_W(32), .MODE(0)) u_lock (
    .clk(clk), .rst(rst),
    .a_valid_i(a_v[0]), .a_data_i(a_d[0]), .b_valid_i(b_v[0]), .b_data_i(b_d[0]),
    .diverged_o(dv[0]), .div_ch_o(dch[0]), .div_cause_o(dcause[0]),
    .div_cycle_o(dcyc[0]), .cycle_o(cyc[0]), .pending_o(pend[0]));

  miter_divergence_monitor #(.NUM_CH(NCH), .DATA_W(DW), .SKEW_DEPTH(SD), .CYC_W(32), .MODE(1)) u_skew (
    .clk(clk), .rst(rst),
    .a_valid_i(a_v[1]), .a_data_i(a_d[1]), .b_valid_i(b_v[1]), .b_data_i(b_d[1]),
    .diverged_o(dv[1]), .div_ch_o(dch[1]), .div_cause_o(dcause[1]),
    .div_cycle_o(dcyc[1]), .cycle_o(cyc[1]), .pending_o(pend[1]));

  miter_divergence_monitor #(.NUM_CH(NCH), .DATA_W(DW), .SKEW_DEPTH(SD), .CYC_W(3), .MODE(0)) u_small (
    .clk(clk), .rst(rst),
    .a_valid_i(z_v), .a_data_i(z_d), .b_valid_i(z_v), .b_data_i(z_d),
    .diverged_o(dv[2]), .div_ch_o(dch[2]), .div_cause_o(dcause[2]),
    .div_cycle_o(dcyc_s), .cycle_o(cyc_s), .pending_o(pend[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic          m_div   [2];
  int            m_ch    [2];
  logic [1:0]    m_cause [2];
  logic [31:0]   m_dcyc  [2];
  logic [31:0]   m_cyc;
  int            m_cyc_s;
  logic [DW-1:0] mq      [NCH][$];
  bit            m_lead  [NCH];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_step();
    logic          av, bv;
    logic [DW-1:0] ad, bd, h;
    logic [1:0]    c;
    if (rst) begin
      for (int u = 0; u < 2; u++) begin
        m_div[u] = 1'b0; m_ch[u] = 0; m_cause[u] = 2'b00; m_dcyc[u] = '0;
      end
      m_cyc   = '0;
      m_cyc_s = 0;
      for (int k = 0; k < NCH; k++) begin
        mq[k].delete();
        m_lead[k] = 1'b0;
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        for (int k = 0; k < NCH; k++) begin
          av = a_v[u][k]; bv = b_v[u][k];
          ad = a_d[u][k*DW +: DW]; bd = b_d[u][k*DW +: DW];
          c  = 2'b00;
          if (u == 0) begin
            if (av != bv) c = 2'b10;
            else if (av && ad != bd) c = 2'b01;
          end else if (av && !bv) begin
            if (mq[k].size() == 0 || !m_lead[k]) begin
              if (mq[k].size() == SD) c = 2'b11;
              else begin mq[k].push_back(ad); m_lead[k] = 1'b0; end
            end else begin
              h = mq[k].pop_front();
              if (h != ad) c = 2'b01;
            end
          end else if (bv && !av) begin
            if (mq[k].size() == 0 || m_lead[k]) begin
              if (mq[k].size() == SD) c = 2'b11;
              else begin mq[k].push_back(bd); m_lead[k] = 1'b1; end
            end else begin
              h = mq[k].pop_front();
              if (h != bd) c = 2'b01;
            end
          end else if (av && bv) begin
            if (mq[k].size() == 0) begin
              if (ad != bd) c = 2'b01;
            end else begin
              h = mq[k].pop_front();
              if (h != (m_lead[k] ? ad : bd)) c = 2'b01;
              mq[k].push_back(m_lead[k] ? bd : ad);
            end
          end
          if (!m_div[u] && c != 2'b00) begin
            m_div[u] = 1'b1; m_ch[u] = k; m_cause[u] = c; m_dcyc[u] = m_cyc;
          end
        end
      end
      if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
      if (m_cyc_s < 7) m_cyc_s = m_cyc_s + 1;
    end
  endtask

  task automatic check_all();
    logic [NCH-1:0] ep;
    for (int k = 0; k < NCH; k++) ep[k] = (mq[k].size() != 0);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("i%0d_div", u), dv[u], m_div[u]);
      chk($sformatf("i%0d_ch", u), dch[u], m_ch[u]);
      chk($sformatf("i%0d_cause", u), dcause[u], m_cause[u]);
      chk($sformatf("i%0d_dcyc", u), dcyc[u], m_dcyc[u]);
      chk($sformatf("i%0d_cyc", u), cyc[u], m_cyc);
    end
    chk("i0_pend", pend[0], '0);
    chk("i1_pend", pend[1], ep);
    chk("s_cyc", cyc_s, m_cyc_s);
    chk("s_div", {dv[2], dch[2], dcause[2], dcyc_s, pend[2]}, '0);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input logic [NCH-1:0] av, input logic [NCH*DW-1:0] ad,
                       input logic [NCH-1:0] bv, input logic [NCH*DW-1:0] bd);
    for (int u = 0; u < 2; u++) begin
      a_v[u] = av; a_d[u] = ad; b_v[u] = bv; b_d[u] = bd;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [DW-1:0] seqv(input int r, input int k, input int idx);
    return DW'((r * 131 + k * 977 + idx * 41) ^ (idx << 5));
  endfunction

  initial begin
    logic [NCH-1:0]    v;
    logic [NCH*DW-1:0] d, d2;
    int ia [NCH];
    int ib [NCH];
    int lim;
    z_v = '0; z_d = '0;
    drive('0, '0, '0, '0);

    // Reset state
    do_reset();
    chk("rst_cyc", cyc[0], 0);
    chk("rst_div", dv[1], 0);

    // Identical streams for 100 cycles
    for (int i = 0; i < 100; i++) begin
      v = NCH'($urandom);
      d = (NCH*DW)'($urandom);
      drive(v, d, v, d);
      tick();
    end
    chk("ident_cyc100", cyc[0], 100);
    chk("ident_nodiv0", dv[0], 0);
    chk("ident_nodiv1", dv[1], 0);

    // Data mismatch on ch1 at cycle 7
    drive('0, '0, '0, '0);
    do_reset();
    for (int i = 0; i < 7; i++) tick();
    d = '0; d[DW +: DW] = DW'(5);
    d2 = '0; d2[DW +: DW] = DW'(6);
    drive(2'b10, d, 2'b10, d2);
    tick();
    drive('0, '0, '0, '0);
    chk("data_div", dv[0], 1);
    chk("data_ch", dch[0], 1);
    chk("data_cause", dcause[0], 2'b01);
    chk("data_dcyc", dcyc[0], 7);

    // Simultaneous events at cycle 3: ch0 valid mismatch beats ch1 data mismatch
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    d = '0; d[DW +: DW] = DW'(1);
    d2 = '0; d2[DW +: DW] = DW'(2);
    drive(2'b11, d, 2'b10, d2);
    tick();
    drive('0, '0, '0, '0);
    chk("prio_ch", dch[0], 0);
    chk("prio_cause", dcause[0], 2'b10);
    chk("prio_dcyc", dcyc[0], 3);

    // Skew: A leads B by three cycles on ch0
    do_reset();
    for (int i = 0; i < 3; i++) begin
      d = '0; d[DW-1:0] = DW'(16'hA1 + i);
      drive(2'b01, d, 2'b00, '0);
      tick();
      chk("skew_pend_a", pend[1][0], 1);
    end
    for (int i = 0; i < 3; i++) begin
      d = '0; d[DW-1:0] = DW'(16'hA1 + i);
      drive(2'b00, '0, 2'b01, d);
      tick();
      chk("skew_pend_b", pend[1][0], (i < 2) ? 1 : 0);
    end
    drive('0, '0, '0, '0);
    tick();
    chk("skew_pend_end", pend[1][0], 0);
    chk("skew_nodiv", dv[1], 0);

    // Overflow: five A beats, no B
    do_reset();
    for (int i = 0; i < 5; i++) begin
      d = '0; d[DW-1:0] = DW'(i + 1);
      drive(2'b01, d, 2'b00, '0);
      tick();
      if (i == 3) chk("ovf_full_nodiv", dv[1], 0);
    end
    chk("ovf_div", dv[1], 1);
    chk("ovf_cause", dcause[1], 2'b11);
    chk("ovf_dcyc", dcyc[1], 4);
    chk("ovf_ch", dch[1], 0);
    chk("ovf_pend", pend[1][0], 1);

    // Reset with full buffer, diverged, and a beat present in the same cycle
    do_reset();
    chk("rst2_cyc", cyc[1], 0);
    chk("rst2_div", dv[1], 0);
    chk("rst2_cause", dcause[1], 0);
    chk("rst2_dcyc", dcyc[1], 0);
    chk("rst2_pend", pend[1], 0);
    for (int i = 0; i < 20; i++) begin
      d = (NCH*DW)'($urandom);
      drive(2'b11, d, 2'b11, d);
      tick();
    end
    chk("rst2_nodiv1", dv[1], 0);
    chk("rst2_nodiv0", dv[0], 0);

    // Randomised rounds: lockstep copy with rare faults, skewed copy with bounded lead
    for (int r = 0; r < 6; r++) begin
      drive('0, '0, '0, '0);
      do_reset();
      for (int k = 0; k < NCH; k++) begin ia[k] = 0; ib[k] = 0; end
      lim = (r % 2 == 1) ? SD : SD + 2;
      for (int c = 0; c < 80; c++) begin
        v = NCH'($urandom);
        d = (NCH*DW)'($urandom);
        a_v[0] = v; a_d[0] = d; b_v[0] = v; b_d[0] = d;
        if ($urandom_range(49) == 0) b_v[0][$urandom_range(NCH-1)] ^= 1'b1;
        if ($urandom_range(49) == 0) b_d[0][$urandom_range(NCH*DW-1)] ^= 1'b1;
        a_v[1] = '0; b_v[1] = '0; a_d[1] = '0; b_d[1] = '0;
        for (int k = 0; k < NCH; k++) begin
          if ($urandom_range(1) == 1 && (ia[k] - ib[k]) < lim) begin
            a_v[1][k] = 1'b1;
            a_d[1][k*DW +: DW] = seqv(r, k, ia[k]);
            ia[k]++;
          end
          if ($urandom_range(1) == 1 && (ib[k] - ia[k]) < lim) begin
            b_v[1][k] = 1'b1;
            b_d[1][k*DW +: DW] = seqv(r, k, ib[k]);
            if ($urandom_range(59) == 0) b_d[1][k*DW] ^= 1'b1;
            ib[k]++;
          end
        end
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/miter_divergence_monitor.md
Name: miter_divergence_monitor

Overview:
- Observes NUM_CH output streams from two copies (A, B) of a design instantiated in a miter and flags the first cycle at which they diverge.
- Successor to the plain two-instance miter: parametrised channel count and width, with a skew-tolerant mode that checks only data and order when timing may differ.
- Sits beside the two instances; outputs feed formal properties or a simulation scoreboard.

Parameters:
- NUM_CH, 2, number of compared channels (1..16).
- DATA_W, 64, payload width per channel.
- SKEW_DEPTH, 4, per-channel buffer entries in skew mode (power of 2, at least 2).
- CYC_W, 32, width of the cycle counter and divergence timestamp.
- MODE, 0: 0 = lockstep (cycle-exact); 1 = skew-tolerant (order and data only).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- a_valid_i  in  NUM_CH  copy-A beat valid, one bit per channel.
- a_data_i  in  NUM_CH*DATA_W  copy-A payload; channel k is bits [k*DATA_W +: DATA_W].
- b_valid_i  in  NUM_CH  copy-B beat valid.
- b_data_i  in  NUM_CH*DATA_W  copy-B payload.
- diverged_o  out  1  sticky divergence flag.
- div_ch_o  out  max(1,clog2(NUM_CH))  channel of the first divergence.
- div_cause_o  out  2  cause code: 00 none, 01 data, 10 valid/timing, 11 skew overflow.
- div_cycle_o  out  CYC_W  cycle count at the first divergence.
- cycle_o  out  CYC_W  cycles since reset, saturating.
- pending_o  out  NUM_CH  per channel: skew buffer non-empty (always 0 in MODE 0).

Behaviour:
- Reset, synchronous on rst=1:
  - All outputs go to 0.
  - Skew buffers are emptied; lead bits cleared.
  - Reset wins over any simultaneous event, including mid-operation with a full buffer.
- cycle_o:
  - Is 0 in the first cycle after reset release.
  - Increments by 1 each cycle and saturates at all-ones without wrapping.
- Per-cycle per-channel event evaluation. Each event is registered: the flag is visible on the next edge, so latency is 1 cycle.
- MODE 0, channel k:
  - a_valid != b_valid -> cause 10.
  - Both valid and data differ -> cause 01.
  - Both invalid -> data ignored.
- MODE 1, channel k:
  - State: FIFO of SKEW_DEPTH entries, plus a lead bit (0 = holds A beats, 1 = holds B beats), meaningful only when the FIFO is non-empty.
  - Only A valid: if FIFO empty or lead=A, push A data and set lead=A. Otherwise (lead=B) pop the head and compare it with A data; mismatch -> cause 01.
  - Only B valid: symmetric to the A-only case.
  - Both valid, FIFO empty: compare A vs B directly; mismatch -> cause 01. The FIFO stays empty.
  - Both valid, FIFO non-empty with lead=X: compare the head with the lagging side's data, pop the head, and push the leading side's data. Occupancy is unchanged.
  - Push into a full FIFO (no simultaneous pop) -> cause 11. The beat is dropped and the FIFO is unchanged.
  - Neither valid: no change.
  - pending_o[k] = FIFO non-empty. Pointers wrap modulo SKEW_DEPTH; occupancy counter is clog2(SKEW_DEPTH)+1 bits wide.
- Divergence capture:
  - On the first cycle with any event, set diverged_o and capture div_ch_o, div_cause_o and div_cycle_o (= cycle_o of the cycle in which the offending beats were sampled).
  - If several channels have events in that cycle, the lowest index wins.
  - Once set, the capture registers freeze until reset. Later events are ignored, but FIFOs keep operating.
- Residual skew is not a divergence. pending_o exposes it, and end-of-run checks use it.

Test Plan:
- MODE 0, NUM_CH=2: identical valid/data streams on both copies for 100 cycles -> diverged_o stays 0 and cycle_o=100.
- MODE 0: at cycle 7, ch1 a_data=0x5, b_data=0x6, both valid -> from cycle 8 diverged_o=1, div_ch_o=1, div_cause_o=01, div_cycle_o=7.
- MODE 0: at cycle 3, ch0 a_valid=1 and b_valid=0 while ch1 also mismatches data in the same cycle -> div_ch_o=0, div_cause_o=10, div_cycle_o=3.
- MODE 1, SKEW_DEPTH=4:
  - A sends 0xA1, 0xA2, 0xA3 on cycles 0-2; B sends the same values on cycles 3-5 -> no divergence.
  - pending_o[0] is 1 in cycles 1-5 and 0 from cycle 6.
- MODE 1: A sends 5 beats with no B beats -> the 5th push sets cause 11, div_cycle_o = cycle of the 5th beat, pending_o[0]=1.
- Assert rst for one cycle with a full FIFO and diverged_o=1 -> the next cycle shows all outputs 0, cycle_o=0, and an empty buffer. A subsequent matching stream produces no divergence.
